conv2d_layer_ctrl: RTL

//  Sequencer for one conv2d layer bank (N parallel conv2d filters sharing load/sof/input_valid/d_in).

---
 rtl/conv2d_layer_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/conv2d_layer_ctrl.sv
// Sequencer for one conv2d layer bank: weight load, gated pixel stream with sof, output beat counting.
// Optional watchdog on LOAD/DRAIN stalls is compiled in with `define CONV_CTRL_TIMEOUT_EN.
module conv2d_layer_ctrl #(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int OUT_W   = 31,
  parameter int OUT_H   = 31,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  output logic        conv_load,
  input  logic        conv_load_success,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        conv_input_valid,
  output logic        conv_sof,
  output logic [31:0] conv_d_in,
  input  logic        conv_output_valid,
  output logic        frame_done,
  output logic        busy,
  output logic        err_timeout
);

  localparam int IN_TOTAL  = IMG_W * IMG_H;
  localparam int OUT_TOTAL = OUT_W * OUT_H;
  localparam int IN_CW     = $clog2(IN_TOTAL + 1);
  localparam int OUT_CW    = $clog2(OUT_TOTAL + 1);
  localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(IN_TOTAL);
  localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(OUT_TOTAL);

  typedef enum logic [2:0] {IDLE, LOAD, READY, STREAM, DRAIN} state_t;

  state_t              state;
  logic [IN_CW-1:0]    in_cnt;
  logic [IN_CW-1:0]    in_nxt;
  logic [OUT_CW-1:0]   out_cnt;
  logic [OUT_CW-1:0]   out_nxt;
  logic                accept;
  logic                last_acc;
  logic                out_en;
  logic                done;

  assign s_ready  = (state == READY) || ((state == STREAM) && (in_cnt < IN_LAST));
  assign accept   = s_valid && s_ready;
  assign in_nxt   = in_cnt + IN_CW'(1);
  assign last_acc = accept && (in_nxt == IN_LAST);
  assign out_en   = conv_output_valid && ((state == STREAM) || (state == DRAIN)) &&
                    (out_cnt != OUT_LAST);
  assign out_nxt  = out_en ? out_cnt + OUT_CW'(1) : out_cnt;
  // The final output beat may coincide with the final accepted pixel, finishing straight from STREAM.
  assign done     = (out_nxt == OUT_LAST) &&
                    ((state == DRAIN) || ((state == STREAM) && last_acc));
  assign busy     = (state == LOAD) || (state == STREAM) || (state == DRAIN);

`ifdef CONV_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            stall;
  logic            wd_fire;

  assign stall   = ((state == LOAD) && !conv_load_success) ||
                   ((state == DRAIN) && !conv_output_valid);
  assign wd_fire = stall && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (!stall || wd_fire) wd_cnt <= '0;
      else                   wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_fire) err_timeout <= 1'b1;
    end
  end
`else
  // Constant low; the comparison only keeps TIMEOUT referenced in this build.
  assign err_timeout = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      in_cnt           <= '0;
      out_cnt          <= '0;
      conv_load        <= 1'b0;
      conv_input_valid <= 1'b0;
      conv_sof         <= 1'b0;
      conv_d_in        <= '0;
      frame_done       <= 1'b0;
    end else begin
      // Pixel path: one registered stage between the upstream handshake and the layer.
      conv_input_valid <= accept;
      conv_sof         <= accept && (state == READY);
      if (accept) conv_d_in <= s_data;
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          if (cfg_start) begin
            conv_load <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (conv_load_success) begin
            conv_load <= 1'b0;
            state     <= READY;
          end
`ifdef CONV_CTRL_TIMEOUT_EN
          else if (wd_fire) begin
            conv_load <= 1'b0;
            state     <= IDLE;
          end
`endif
        end
        READY: begin
          if (accept) begin
            in_cnt <= in_nxt;
            state  <= STREAM;
          end
        end
        STREAM: begin
          out_cnt <= out_nxt;
          if (accept) in_cnt <= in_nxt;
          if (done) begin
            frame_done <= 1'b1;
            in_cnt     <= '0;
            out_cnt    <= '0;
            state      <= READY;
          end else if (last_acc) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          out_cnt <= out_nxt;
          if (done) begin
            frame_done <= 1'b1;
            in_cnt     <= '0;
            out_cnt    <= '0;
            state      <= READY;
          end
`ifdef CONV_CTRL_TIMEOUT_EN
          else if (wd_fire) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            state   <= READY;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
